// File: rtl/beat_pkg.sv
// Shared constants for the beat recorder: state codes, the rest note code
// and the default geometry used by the sequencer, keyboard decoder and buzzer.
package beat_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'b00;
    localparam state_t RECORD = 2'b01;
    localparam state_t PLAY   = 2'b11;

    localparam int NOTE_REST = 0;

    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NOTE_W   = 4;
    localparam int DEF_TICK_DIV = 12500000;

endpackage

// File: rtl/beat_sequencer_ticker.sv
// Beat divider: counts 0..TICK_DIV-1 and raises tick for the cycle in which
// the count sits at TICK_DIV-1. A synchronous clear restarts the count.
module beat_ticker
    import beat_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_LAST);

    // Free-running beat counter; clear wins over the natural wrap.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/beat_sequencer.sv
// Beat RAM sequencer: records one keyboard note per beat into consecutive RAM
// slots and loops the stored beats back to the buzzer in play mode. Owns all
// RAM address and write-enable generation.
module beat_sequencer
    import beat_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NOTE_W   = DEF_NOTE_W,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mode_record,
    input  logic              mode_play,
    input  logic [NOTE_W-1:0] key_note,
    input  logic              key_valid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [NOTE_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [NOTE_W-1:0] ram_rdata,
    output logic [NOTE_W-1:0] play_note,
    output logic              play_valid,
    output logic [ADDR_W:0]   rec_len,
    output logic              rec_full,
    output logic [1:0]        state_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);
    localparam logic [NOTE_W-1:0] REST      = NOTE_W'(NOTE_REST);

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              tick;
    logic              tick_clr;
    logic              wr_en;
    logic              wr_last;
    logic              rd_en;
    logic              rd_last;
    logic              rd_pend;
    // Set when a recording filled the RAM while the switch is still up, so
    // the held switch does not immediately start a new take over the old one.
    logic              rec_block;

    // The exit on a falling mode_record wins over a coincident tick.
    assign wr_en   = resetn && (state == RECORD) && mode_record && tick;
    assign wr_last = (wr_ptr == LAST_ADDR);
    assign rd_en   = (state == PLAY) && mode_play && tick && (rec_len != '0);
    assign rd_last = ({1'b0, rd_ptr} == (rec_len - LEN_ONE));

    // Every state entry restarts the beat so the first tick is a full beat away.
    assign tick_clr = !resetn || (state_n != state);

    beat_ticker #(
        .TICK_DIV (TICK_DIV)
    ) u_ticker (
        .clk  (clk),
        .clr  (tick_clr),
        .tick (tick)
    );

    // Next-state selection; record has priority over play out of IDLE.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (mode_record && !rec_block) begin
                    state_n = RECORD;
                end else if (mode_play) begin
                    state_n = PLAY;
                end
            end
            RECORD: begin
                if (!mode_record || (wr_en && wr_last)) begin
                    state_n = IDLE;
                end
            end
            PLAY: begin
                if (!mode_play) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Re-arm recording only once the switch has been released after a full take.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rec_block <= 1'b0;
        end else if (!mode_record) begin
            rec_block <= 1'b0;
        end else if (wr_en && wr_last) begin
            rec_block <= 1'b1;
        end
    end

    // Write pointer and recording length; a full RAM stops without wrapping.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rec_len  <= '0;
            rec_full <= 1'b0;
        end else if ((state != RECORD) && (state_n == RECORD)) begin
            wr_ptr   <= '0;
            rec_len  <= '0;
            rec_full <= 1'b0;
        end else if (wr_en) begin
            wr_ptr  <= wr_ptr + 1'b1;
            rec_len <= rec_len + LEN_ONE;
            if (wr_last) begin
                rec_full <= 1'b1;
            end
        end
    end

    // Read pointer loops over the recorded beats; note lands one cycle after the RAM read.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr     <= '0;
            rd_pend    <= 1'b0;
            play_note  <= REST;
            play_valid <= 1'b0;
        end else begin
            rd_pend <= rd_en;
            if ((state != PLAY) && (state_n == PLAY)) begin
                rd_ptr <= '0;
            end else if (rd_en) begin
                rd_ptr <= rd_last ? '0 : (rd_ptr + 1'b1);
            end
            if ((state != PLAY) || (state_n != PLAY)) begin
                play_note  <= REST;
                play_valid <= 1'b0;
            end else if (rd_pend) begin
                play_note  <= ram_rdata;
                play_valid <= 1'b1;
            end
        end
    end

    assign ram_addr  = (state == PLAY) ? rd_ptr : wr_ptr;
    assign ram_we    = wr_en;
    assign ram_wdata = (wr_en && key_valid) ? key_note : REST;
    assign state_o   = state;

endmodule

// File: doc/beat_sequencer.md
Name: beat_sequencer

Overview:
- Sequences the beat RAM for the recorder.
- In record mode it samples the live keyboard note once per beat tick and writes it to consecutive RAM slots.
- In play mode it reads the recorded slots back in a loop and drives the buzzer note.
- Sits between the mode switches/keyboard decoder and the single-port beat RAM, and owns all RAM address and write-enable generation.

Parameters:
- ADDR_W, 5, RAM address width; capacity is 2**ADDR_W beats.
- NOTE_W, 4, note code width; code 0 means rest.
- TICK_DIV, 12500000, clk cycles per beat (4 beats/s at 50 MHz); must be >= 3.

Ports:
- clk  input  1  system clock
- resetn  input  1  synchronous active-low reset
- mode_record  input  1  level; record request (SW[0])
- mode_play  input  1  level; playback request (SW[1])
- key_note  input  NOTE_W  currently pressed note code
- key_valid  input  1  a key is held
- ram_addr  output  ADDR_W  RAM address
- ram_wdata  output  NOTE_W  RAM write data
- ram_we  output  1  RAM write enable, one-cycle pulse
- ram_rdata  input  NOTE_W  RAM read data; synchronous, 1-cycle latency
- play_note  output  NOTE_W  note to buzzer during playback
- play_valid  output  1  play_note is meaningful
- rec_len  output  ADDR_W+1  number of beats in the stored recording
- rec_full  output  1  last recording filled the RAM
- state_o  output  2  current state code, for LEDs/debug

Behaviour:
- Reset (resetn=0 at a clk edge) forces the following; the recording is discarded, including on reset mid-record or mid-play:
  - state=IDLE, tick counter=0, wr_ptr=0, rd_ptr=0
  - rec_len=0, rec_full=0
  - ram_we=0, ram_wdata=0
  - play_note=0, play_valid=0
- State codes: IDLE=2'b00, RECORD=2'b01, PLAY=2'b11.
- Transitions are evaluated every clk edge:
  - IDLE -> RECORD if mode_record. Else IDLE -> PLAY if mode_play. Record has priority when both are set.
  - RECORD -> IDLE when mode_record=0, or after the write to address 2**ADDR_W-1.
  - PLAY -> IDLE when mode_play=0. mode_record is ignored in PLAY until PLAY exits.
- Beat ticker:
  - Counter runs 0..TICK_DIV-1; tick is asserted for the cycle in which counter==TICK_DIV-1, then the counter wraps to 0.
  - Counter is cleared on every state entry, so the first tick occurs TICK_DIV cycles after entry.
- RECORD:
  - Entry clears wr_ptr=0, rec_len=0, rec_full=0. The previous recording is overwritten.
  - On each tick: ram_we=1 for exactly that cycle, ram_addr=wr_ptr, ram_wdata=key_valid ? key_note : 0.
  - Next cycle: wr_ptr+1 and rec_len+1.
  - Write at wr_ptr=2**ADDR_W-1: rec_len becomes 2**ADDR_W, rec_full=1, state -> IDLE. No wrap; no further writes occur.
  - Exit by switch: rec_len holds the number of completed writes.
  - A tick coinciding with the mode_record falling edge is not written; the exit wins.
- PLAY:
  - Entry clears rd_ptr=0 and play_valid=0.
  - If rec_len=0: no reads are issued, and play_valid and play_note stay 0.
  - Otherwise on each tick: ram_addr=rd_ptr; the cycle after, play_note<=ram_rdata and play_valid<=1.
  - rd_ptr then advances, wrapping to 0 after rec_len-1, so playback loops indefinitely.
  - play_note holds its value between ticks.
- ram_addr = wr_ptr in RECORD/IDLE and rd_ptr in PLAY.
- ram_we is only ever 1 in RECORD on a tick cycle.
- Leaving PLAY clears play_valid and play_note the next cycle.
- Pointer arithmetic is ADDR_W-bit unsigned. rec_len is ADDR_W+1 bits so the value 2**ADDR_W is representable.

Decomposition:
- Shared package (beat_pkg) holds:
  - state codes IDLE/RECORD/PLAY
  - NOTE_REST=0
  - default ADDR_W, NOTE_W and TICK_DIV constants, reused by the keyboard decoder and buzzer blocks
- One sub-module: beat_ticker, a parameterised divider with a synchronous clear input and a tick output.
- FSM, pointers and RAM interface stay in beat_sequencer.

Test Plan:
Bench uses TICK_DIV=4, ADDR_W=3, with a behavioural 8x4 sync RAM model.
- Record 3 beats: mode_record=1; key_note=5/valid, then no key, then key_note=9/valid at ticks 1-3, then drop mode_record -> writes (0,5), (1,0), (2,9) on cycles 4, 8, 12 after entry; rec_len=3, rec_full=0, state IDLE.
- Playback loop: after the above, mode_play=1 -> play_note sequence 5, 0, 9, 5, 0, 9, each updated 1 cycle after its tick; play_valid=1 from the first update.
- Fill: hold mode_record for 9+ ticks -> exactly 8 writes to addresses 0..7, rec_len=8, rec_full=1, auto-return to IDLE while the switch is still high.
- Empty play: play with rec_len=0 after reset -> ram_we=0 throughout, play_valid=0, play_note=0.
- Priority/exit: both switches high in IDLE -> RECORD. Drop mode_record on a tick cycle -> no write that cycle, state IDLE.
- Reset mid-record: resetn=0 for one clk after 2 writes -> all outputs 0, rec_len=0; a later play produces no notes.
